// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron weight update path: default sizes,
// the updater FSM state encoding, the default-width signed weight type and a
// saturating 16-bit magnitude helper.
package perceptron_pkg;

    localparam int DEFAULT_HISTORY_LENGTH = 32;
    localparam int DEFAULT_WEIGHT_WIDTH   = 8;

    // Updater sequencing: IDLE accepts, CHECK decides train/skip,
    // UPDATE walks the lane groups, DONE holds the result for the consumer.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Signed perceptron weight at the default width.
    typedef logic signed [DEFAULT_WEIGHT_WIDTH-1:0] weight_t;

    // |v| for a signed 16-bit value; -32768 has no positive twin and
    // saturates to 32767.
    function automatic logic [15:0] sat_abs16(input logic signed [15:0] v);
        logic [15:0] mag;
        mag = v[15] ? (~v + 16'd1) : v;
        if (mag[15]) begin
            mag = 16'h7FFF;
        end
        return mag;
    endfunction

endpackage

// File: rtl/perceptron_weight_updater_sat.sv
// weight_sat_adjust: moves one signed weight by +1 or -1, clamped to the
// representable range (no wrap-around). Purely combinational, zero latency.
// Ports: weight (current), inc (1 = +1, 0 = -1), weight_next (result).
module weight_sat_adjust #(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0] weight,
    input  logic                    inc,
    output logic signed [WIDTH-1:0] weight_next
);

    localparam logic signed [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        weight_next = weight;
        if (inc) begin
            if (weight != W_MAX) begin
                weight_next = weight + WIDTH'(1);
            end
        end else begin
            if (weight != W_MIN) begin
                weight_next = weight - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/perceptron_weight_updater.sv
// perceptron_weight_updater: trains one perceptron weight vector per request.
// Latency: CHECK one cycle after acceptance, then ceil((HISTORY_LENGTH+1)/LANES)
//   UPDATE cycles when training, then DONE; no training goes CHECK -> DONE.
// Backpressure: req_ready only in IDLE; the result is held in DONE until out_ready.
// Ports: clk/rst (async active-high); req_valid/req_ready with history,
//   weights_in (index HISTORY_LENGTH is bias), dot_product, actual_taken;
//   out_valid/out_ready with weights_out and trained.
// Optional: define PERCEPTRON_UPDATE_STATS_EN to add saturating 32-bit
//   train_count / skip_count outputs, bumped once per request in CHECK.
module perceptron_weight_updater
    import perceptron_pkg::*;
#(
    parameter int HISTORY_LENGTH = DEFAULT_HISTORY_LENGTH,
    parameter int WEIGHT_WIDTH   = DEFAULT_WEIGHT_WIDTH,
    parameter int THRESHOLD      = 75,
    parameter int LANES          = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [HISTORY_LENGTH-1:0]      history,
    input  logic signed [WEIGHT_WIDTH-1:0] weights_in [0:HISTORY_LENGTH],
    input  logic signed [15:0]             dot_product,
    input  logic                           actual_taken,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [WEIGHT_WIDTH-1:0] weights_out [0:HISTORY_LENGTH],
    output logic                           trained
`ifdef PERCEPTRON_UPDATE_STATS_EN
    ,
    output logic [31:0]                    train_count,
    output logic [31:0]                    skip_count
`endif
);

    localparam int NUM_W      = HISTORY_LENGTH + 1;
    localparam int NUM_GROUPS = (NUM_W + LANES - 1) / LANES;
    localparam int AW         = (NUM_W > 1) ? $clog2(NUM_W) : 1;
    // Wide enough that base + LANES never overflows on the final group.
    localparam int IW         = $clog2(NUM_GROUPS * LANES + 1);

    localparam logic [AW-1:0] BIAS_IDX = AW'(HISTORY_LENGTH);
    localparam logic [IW-1:0] NUM_W_I  = IW'(NUM_W);
    localparam logic [IW-1:0] LANES_I  = IW'(LANES);
    localparam logic [15:0]   THRESH16 = 16'(THRESHOLD);

    state_t                    state;
    logic [HISTORY_LENGTH-1:0] hist_q;
    logic signed [15:0]        dot_q;
    logic                      taken_q;
    // First weight index handled by the current UPDATE cycle.
    logic [IW-1:0]             base;

    // ------------------------------------------------------------------
    // Train/skip decision, evaluated from the latched request in CHECK.
    // ------------------------------------------------------------------
    logic        pred_taken;
    logic        mispredict;
    logic [15:0] abs_dot;
    logic        do_train;

    always_comb begin
        pred_taken = ~dot_q[15];
        mispredict = (pred_taken != taken_q);
        abs_dot    = sat_abs16(dot_q);
        do_train   = mispredict || (abs_dot <= THRESH16);
    end

    // ------------------------------------------------------------------
    // Lane datapath. The bias is appended above the history so a single
    // index selects both; the bias itself moves towards the outcome
    // rather than towards agreement with a history bit.
    // ------------------------------------------------------------------
    logic [NUM_W-1:0]          hist_ext;
    logic [IW-1:0]             lane_idx [LANES];
    logic                      lane_en  [LANES];
    logic [AW-1:0]             lane_sel [LANES];
    logic                      lane_inc [LANES];
    logic signed [WEIGHT_WIDTH-1:0] lane_cur [LANES];
    logic signed [WEIGHT_WIDTH-1:0] lane_nxt [LANES];
    logic                      last_group;

    assign hist_ext   = {taken_q, hist_q};
    assign last_group = (base + LANES_I) >= NUM_W_I;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = base + IW'(l);
        // Lanes past the bias in a partial final group do nothing.
        assign lane_en[l]  = lane_idx[l] < NUM_W_I;
        assign lane_sel[l] = lane_idx[l][AW-1:0];
        assign lane_inc[l] = (lane_sel[l] == BIAS_IDX) ? taken_q
                                                       : (hist_ext[lane_sel[l]] == taken_q);
        assign lane_cur[l] = lane_en[l] ? weights_out[lane_sel[l]] : '0;

        weight_sat_adjust #(
            .WIDTH(WEIGHT_WIDTH)
        ) u_weight_sat_adjust (
            .weight      (lane_cur[l]),
            .inc         (lane_inc[l]),
            .weight_next (lane_nxt[l])
        );
    end

    assign req_ready = (state == ST_IDLE);

    // ------------------------------------------------------------------
    // Sequencer. weights_out doubles as the working copy: it is loaded at
    // acceptance and edited in place lane group by lane group, so in the
    // skip case it already equals the latched weights.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            hist_q    <= '0;
            dot_q     <= '0;
            taken_q   <= 1'b0;
            base      <= '0;
            out_valid <= 1'b0;
            trained   <= 1'b0;
            for (int i = 0; i < NUM_W; i++) begin
                weights_out[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        hist_q  <= history;
                        dot_q   <= dot_product;
                        taken_q <= actual_taken;
                        base    <= '0;
                        for (int i = 0; i < NUM_W; i++) begin
                            weights_out[i] <= weights_in[i];
                        end
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (do_train) begin
                        state <= ST_UPDATE;
                    end else begin
                        out_valid <= 1'b1;
                        trained   <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                ST_UPDATE: begin
                    for (int l = 0; l < LANES; l++) begin
                        if (lane_en[l]) begin
                            weights_out[lane_sel[l]] <= lane_nxt[l];
                        end
                    end
                    if (last_group) begin
                        base      <= '0;
                        out_valid <= 1'b1;
                        trained   <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        base <= base + LANES_I;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        trained   <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PERCEPTRON_UPDATE_STATS_EN
    // One count per request, taken when CHECK makes its decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            train_count <= '0;
            skip_count  <= '0;
        end else if (state == ST_CHECK) begin
            if (do_train) begin
                if (train_count != '1) begin
                    train_count <= train_count + 32'd1;
                end
            end else begin
                if (skip_count != '1) begin
                    skip_count <= skip_count + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_perceptron_weight_updater.sv
// Testbench for perceptron_weight_updater (default parameters, LANES=4).
// A driver issues directed and random requests and queues the expected
// result; an independent monitor pops and checks whenever out_valid is seen.
module tb_perceptron_weight_updater;
    import perceptron_pkg::*;

    localparam int H      = 32;
    localparam int NW     = H + 1;
    localparam int LANES  = 4;
    localparam int THRESH = 75;
    localparam int GROUPS = (NW + LANES - 1) / LANES;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [H-1:0] history = '0;
    logic signed [7:0] weights_in [0:H];
    logic signed [15:0] dot_product = '0;
    logic        actual_taken = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic signed [7:0] weights_out [0:H];
    logic        trained;
`ifdef PERCEPTRON_UPDATE_STATS_EN
    logic [31:0] train_count;
    logic [31:0] skip_count;
`endif

    perceptron_weight_updater #(
        .HISTORY_LENGTH(H), .WEIGHT_WIDTH(8), .THRESHOLD(THRESH), .LANES(LANES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .history      (history),
        .weights_in   (weights_in),
        .dot_product  (dot_product),
        .actual_taken (actual_taken),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .weights_out  (weights_out),
        .trained      (trained)
`ifdef PERCEPTRON_UPDATE_STATS_EN
        ,
        .train_count  (train_count),
        .skip_count   (skip_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        weight_t w [0:H];
        logic    trained;
        int      due;
    } exp_t;

    exp_t exp_q [$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_train_n = 0;
    int   exp_skip_n  = 0;
    int   hold_next   = -1;

    // Stimulus scratch, filled before each call to issue().
    logic [H-1:0] stim_h;
    int           stim_w [0:H];
    int           stim_dot;
    logic         stim_taken;

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Expected outcome from the training rule in plain integer arithmetic.
    function automatic exp_t model(output bit train);
        exp_t e;
        int   mag;
        bit   agree;
        int   v;
        mag   = (stim_dot < 0) ? -stim_dot : stim_dot;
        train = ((stim_dot >= 0) != stim_taken) || (mag <= THRESH);
        for (int i = 0; i < NW; i++) begin
            agree = (i < H) ? (stim_h[i] == stim_taken) : stim_taken;
            v = stim_w[i];
            if (train) begin
                v = v + (agree ? 1 : -1);
                if (v > 127)  v = 127;
                if (v < -128) v = -128;
            end
            e.w[i] = weight_t'(v);
        end
        e.trained = train;
        e.due = 0;
        return e;
    endfunction

    function automatic int rand_weight();
        case ($urandom_range(0, 5))
            0: return 127;
            1: return -128;
            2: return 126;
            3: return -127;
            default: return int'($urandom_range(0, 255)) - 128;
        endcase
    endfunction

    task automatic randomize_stim();
        stim_h     = $urandom;
        stim_taken = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) stim_dot = int'($urandom_range(0, 65535)) - 32768;
        else                           stim_dot = int'($urandom_range(0, 400)) - 200;
        for (int i = 0; i < NW; i++) stim_w[i] = rand_weight();
    endtask

    // Waits for IDLE while waving junk at the (busy) DUT, then presents the
    // real request for exactly one accepting edge. Returns the accept cycle.
    task automatic issue(input bit push, output int t_acc);
        int   guard;
        exp_t e;
        bit   train;
        guard = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            req_valid    = 1'($urandom_range(0, 1));
            history      = $urandom;
            dot_product  = 16'($urandom);
            actual_taken = 1'($urandom_range(0, 1));
            for (int i = 0; i < NW; i++) weights_in[i] = 8'($urandom);
            guard++;
            if (guard > 300) begin
                checks++; failures++;
                $display("FAIL req_ready_timeout: req_ready stayed 0 for %0d cycles, required 1", guard);
                finish_run();
            end
        end
        req_valid    = 1'b1;
        history      = stim_h;
        dot_product  = 16'(stim_dot);
        actual_taken = stim_taken;
        for (int i = 0; i < NW; i++) weights_in[i] = 8'(stim_w[i]);
        @(posedge clk);
        #1;
        t_acc = cyc - 1;
        req_valid = 1'b0;
        e = model(train);
        e.due = t_acc + 2 + (train ? GROUPS : 0);
        if (train) exp_train_n++; else exp_skip_n++;
        if (push) exp_q.push_back(e);
    endtask

    task automatic run_stim();
        int t;
        issue(1'b1, t);
    endtask

    // ---------------------------------------------------------------- monitor
    exp_t cur;
    bit   have_cur = 0;
    int   hold_left = 0;

    function automatic int first_diff(input exp_t e);
        for (int i = 0; i < NW; i++) if (weights_out[i] !== e.w[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        int d;
        if (rst) begin
            have_cur = 0;
        end else if (out_valid) begin
            if (!have_cur) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output: out_valid=1 at cycle %0d, required no pending result", cyc);
                    out_ready = 1'b1;
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1;
                    d = first_diff(cur);
                    if (d >= 0) begin
                        failures++;
                        $display("FAIL weights_out[%0d]: got %0d, required %0d", d, weights_out[d], cur.w[d]);
                    end
                    checks++;
                    if (trained !== cur.trained) begin
                        failures++;
                        $display("FAIL trained: got %b, required %b", trained, cur.trained);
                    end
                    checks++;
                    if (cyc != cur.due) begin
                        failures++;
                        $display("FAIL latency: out_valid first at cycle %0d, required %0d", cyc, cur.due);
                    end
                    hold_left = (hold_next >= 0) ? hold_next : int'($urandom_range(0, 3));
                    hold_next = -1;
                end
            end else begin
                checks++;
                d = first_diff(cur);
                if (d >= 0 || trained !== cur.trained) begin
                    failures++;
                    $display("FAIL hold_stable: weights/trained changed while held (idx %0d trained %b), required %b",
                             d, trained, cur.trained);
                end
            end
            if (have_cur) begin
                if (hold_left == 0) begin
                    out_ready = 1'b1;
                    have_cur  = 0;
                end else begin
                    hold_left--;
                    out_ready = 1'b0;
                end
            end
        end else begin
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic check_idle_after_reset(input string tag);
        int nz;
        nz = 0;
        for (int i = 0; i < NW; i++) if (weights_out[i] !== 8'sd0) nz++;
        checks++;
        if (out_valid !== 1'b0 || trained !== 1'b0) begin
            failures++;
            $display("FAIL %s_outputs: out_valid=%b trained=%b, required 0 0", tag, out_valid, trained);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_req_ready: got %b, required 1", tag, req_ready);
        end
        checks++;
        if (nz != 0) begin
            failures++;
            $display("FAIL %s_weights: %0d nonzero weights, required 0", tag, nz);
        end
    endtask

    // ---------------------------------------------------------------- driver
    initial begin
        int t;
        int guard;
        for (int i = 0; i < NW; i++) weights_in[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_after_reset("reset");

        // All-zero weights, all-ones history, mispredicted taken: all +1.
        stim_h = '1; stim_taken = 1'b1; stim_dot = -10;
        for (int i = 0; i < NW; i++) stim_w[i] = 0;
        run_stim();

        // Correct and confident: skip, weights unchanged.
        randomize_stim(); stim_dot = 200; stim_taken = 1'b1;
        run_stim();

        // Exactly at threshold and just above it.
        randomize_stim(); stim_dot = THRESH; stim_taken = 1'b1;
        run_stim();
        randomize_stim(); stim_dot = THRESH + 1; stim_taken = 1'b1;
        run_stim();
        randomize_stim(); stim_dot = -THRESH; stim_taken = 1'b0;
        run_stim();

        // Saturation at both rails, then bias stepping down from the top.
        randomize_stim(); stim_taken = 1'b1; stim_dot = -10;
        stim_h[0] = 1'b1; stim_w[0] = 127;
        stim_h[1] = 1'b0; stim_w[1] = -128;
        run_stim();
        randomize_stim(); stim_taken = 1'b0; stim_dot = 5; stim_w[H] = 127;
        run_stim();

        // Most negative dot product, correctly predicted not-taken.
        randomize_stim(); stim_dot = -32768; stim_taken = 1'b0;
        run_stim();

        // Consumer stalls 5 cycles in DONE while junk requests arrive.
        randomize_stim(); stim_dot = 1000; stim_taken = 1'b1;
        hold_next = 5;
        run_stim();

        // Reset during the third UPDATE cycle discards the request.
        randomize_stim(); stim_dot = -10; stim_taken = 1'b1;
        issue(1'b0, t);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        exp_train_n = 0;
        exp_skip_n  = 0;
        #1;
        check_idle_after_reset("midreset");

        randomize_stim(); stim_dot = -10; stim_taken = 1'b1;
        run_stim();

        for (int n = 0; n < 60; n++) begin
            randomize_stim();
            run_stim();
        end

        guard = 0;
        while ((exp_q.size() != 0 || have_cur) && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end

`ifdef PERCEPTRON_UPDATE_STATS_EN
        checks++;
        if (train_count !== 32'(exp_train_n)) begin
            failures++;
            $display("FAIL train_count: got %0d, required %0d", train_count, exp_train_n);
        end
        checks++;
        if (skip_count !== 32'(exp_skip_n)) begin
            failures++;
            $display("FAIL skip_count: got %0d, required %0d", skip_count, exp_skip_n);
        end
`endif
        finish_run();
    end

endmodule

// File: doc/perceptron_weight_updater.md
PERCEPTRON_WEIGHT_UPDATER -- requirements
Module: perceptron_weight_updater

Interface
REQ-001 SHALL have parameter HISTORY_LENGTH, default 32, global history bits per prediction.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 8, signed weight width.
REQ-003 SHALL have parameter THRESHOLD, default 75, training threshold on |dot_product|.
REQ-004 SHALL have parameter LANES, default 4, weights updated per cycle (1..HISTORY_LENGTH+1).
REQ-005 SHALL have ports clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset.
REQ-006 SHALL have port req_valid in 1, update request.
REQ-007 SHALL have port req_ready out 1, high only in IDLE.
REQ-008 SHALL have port history in HISTORY_LENGTH, history used at prediction.
REQ-009 SHALL have port weights_in in signed WEIGHT_WIDTH x (HISTORY_LENGTH+1), current weights; index HISTORY_LENGTH is bias.
REQ-010 SHALL have port dot_product in signed 16, predictor output for this branch.
REQ-011 SHALL have port actual_taken in 1, resolved outcome.
REQ-012 SHALL have port out_valid out 1, result available.
REQ-013 SHALL have port out_ready in 1, consumer accepts result.
REQ-014 SHALL have port weights_out out signed WEIGHT_WIDTH x (HISTORY_LENGTH+1), updated weights.
REQ-015 SHALL have port trained out 1, high with out_valid when weights were changed.

Function
REQ-016 SHALL accept a request on the cycle with req_valid && req_ready, and latch history, weights_in, dot_product and actual_taken.
REQ-017 SHALL implement FSM IDLE -> CHECK -> (UPDATE | DONE); UPDATE -> DONE after the last lane group; DONE -> IDLE on out_ready.
REQ-018 SHALL set predicted taken = (dot_product >= 0) and mispredict = predicted != actual_taken.
REQ-019 SHALL compute |dot_product| saturated to 32767 (-32768 maps to 32767).
REQ-020 SHALL train, decided in CHECK, when mispredict or |dot_product| <= THRESHOLD; otherwise SHALL skip to DONE with weights_out equal to the latched weights and trained=0.
REQ-021 SHALL apply per weight i < HISTORY_LENGTH: +1 when history[i] == actual_taken, else -1; bias: +1 when actual_taken, else -1.
REQ-022 SHALL saturate each weight to [-2^(WEIGHT_WIDTH-1), 2^(WEIGHT_WIDTH-1)-1]; no wrap-around.
REQ-023 SHALL process LANES consecutive indices per UPDATE cycle, starting at index 0; the final group is partial when (HISTORY_LENGTH+1) is not a multiple of LANES, and indices beyond the bias are ignored.
REQ-024 SHALL have latency, from acceptance at cycle T: CHECK at T+1; UPDATE at T+2 .. T+1+ceil((HISTORY_LENGTH+1)/LANES); out_valid the following cycle. With no training, out_valid at T+2.
REQ-025 SHALL hold out_valid, weights_out and trained stable until out_ready; it SHALL accept no new request before returning to IDLE.
REQ-026 SHALL ignore req_valid outside IDLE, and out_ready when out_valid=0.

Reset
REQ-027 SHALL, on rst (asynchronous, any state, including mid-UPDATE), force IDLE, out_valid=0, trained=0, weights_out all 0, lane index 0, and discard the in-flight request.
REQ-028 SHALL drive req_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-029 SHALL, with macro PERCEPTRON_UPDATE_STATS_EN defined, add outputs train_count and skip_count (32 bits each, reset 0, saturating). These increment once per request at the CHECK decision.
REQ-030 SHALL, without PERCEPTRON_UPDATE_STATS_EN, have neither those ports nor their counter logic; all other behaviour is identical.

Structure
REQ-031 SHALL take HISTORY_LENGTH/WEIGHT_WIDTH defaults, the FSM state enum and the signed weight typedef from shared package perceptron_pkg.
REQ-032 SHALL instantiate sub-module weight_sat_adjust (combinational: weight, inc/dec -> saturated weight) once per lane.

Verification
REQ-033 SHALL be verified: dot=-10, actual_taken=1 (mispredict), all weights 0, history=32'hFFFF_FFFF -> all 33 weights become +1, trained=1, out_valid at T+11 (LANES=4).
REQ-034 SHALL be verified: dot=200, actual_taken=1 (correct, above THRESHOLD) -> weights_out equals weights_in, trained=0, out_valid at T+2.
REQ-035 SHALL be verified: dot=75 (equal to THRESHOLD), correct prediction -> training occurs, trained=1.
REQ-036 SHALL be verified: weight 127 with increment -> stays 127; weight -128 with decrement -> stays -128; bias 127, actual_taken=0 -> 126.
REQ-037 SHALL be verified: rst pulsed in the 3rd UPDATE cycle -> out_valid=0, req_ready=1 next cycle; a following request completes normally.
REQ-038 SHALL be verified: out_ready held low 5 cycles in DONE -> outputs stable, req_valid ignored; with PERCEPTRON_UPDATE_STATS_EN defined, counters equal to the number of train/skip requests.
